ofm_drain: RTL
==============

OFM_DRAIN -- requirements
Module: ofm_drain

Interface
REQ-001 Parameter IWIDTH, default 8: requantized output width; matches PE input width.
REQ-002 Parameter OWIDTH, default 16: partial-sum width arriving from the last PE of a column.
REQ-003 Parameter DEPTH, default 4: output FIFO entries; power of two, at least 2.
REQ-004 clk  input  1: single clock; all state on rising edge.
REQ-005 rst_n  input  1: reset, asynchronous and active-low.
REQ-006 mac_done  input  1: mac_done_d from the last PE in the column; its rising edge marks ofm as final.
REQ-007 ofm  input  signed OWIDTH: accumulated sum (ofm_d of the last PE).
REQ-008 shift  input  4: right-shift amount for requantization, range 0..OWIDTH-1; sampled together with ofm.
REQ-009 clr  input  1: synchronous clear of FIFO, pipeline and sticky flags.
REQ-010 out_valid  output  1: out_data holds a valid result.
REQ-011 out_ready  input  1: downstream accepts; a transfer occurs when out_valid and out_ready are both 1.
REQ-012 out_data  output  signed IWIDTH: requantized result at the FIFO head.
REQ-013 sat  output  1: sticky; set when any result saturated.
REQ-014 drop  output  1: sticky; set when a result was lost to a full FIFO.
REQ-015 count  output  8: number of results accepted into the FIFO, modulo 256.

Function
REQ-016 The block SHALL register mac_done each cycle and detect a capture event when mac_done is 1 and the registered value is 0; a held-high mac_done produces exactly one capture.
REQ-017 On a capture event in cycle N, ofm and shift SHALL be latched into stage register S1 at the end of cycle N.
REQ-018 Requantization from S1 SHALL be computed in OWIDTH+1 bits:
 - if shift > 0, add 2^(shift-1) (round half up);
 - arithmetic right shift by shift;
 - saturate to [-2^(IWIDTH-1), 2^(IWIDTH-1)-1] (default -128..127).
REQ-019 The requantized value SHALL be written to the FIFO at the end of cycle N+1. out_valid SHALL be 1 in cycle N+2 when the FIFO was previously empty, giving a latency of 2 cycles from the mac_done rising edge.
REQ-020 A write that saturates SHALL set sat; sat SHALL stay set until clr or reset.
REQ-021 The FIFO SHALL be first-in first-out. out_data SHALL present the head entry and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Full FIFO with a write and no pop in the same cycle: the new value SHALL be discarded, drop set, count unchanged.
REQ-023 Full FIFO with a write and a pop in the same cycle: both SHALL occur; occupancy stays DEPTH and drop stays clear.
REQ-024 Empty FIFO: out_valid=0; out_ready is ignored; no pointer change.
REQ-025 Capture events on consecutive rising edges spaced 2 or more cycles apart SHALL all be processed; the S1 stage holds one entry per cycle and never stalls.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; count SHALL wrap from 255 to 0.
REQ-027 clr=1 SHALL, at the end of that cycle:
 - empty the FIFO and invalidate S1;
 - clear sat, drop and count;
 - discard any capture or write in the same cycle.
 out_valid SHALL be 0 the following cycle.
REQ-028 clr SHALL NOT clear the registered mac_done, so a mac_done held high across clr produces no new capture.

Reset
REQ-029 While rst_n=0, the following SHALL be 0 asynchronously: out_valid, out_data, sat, drop, count, both FIFO pointers, S1 valid and registered mac_done.
REQ-030 A mac_done already high when rst_n deasserts SHALL produce a capture in the first cycle after deassertion.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered results; no partial state SHALL survive.

Verification
REQ-032 Basic path: ofm=1000, shift=3, mac_done rises in cycle 10 with out_ready=1.
 -> out_valid=1 in cycle 12; out_data=125 ((1000+4)>>3); sat=0; count=1.
REQ-033 Rounding and saturation:
 - ofm=-1000, shift=2 -> out_data=-128, sat=1;
 - ofm=-6, shift=2 -> out_data=-1 ((-6+2)>>2);
 - ofm=300, shift=0 -> out_data=127.
REQ-034 Backpressure: out_ready=0, five results with ofm=1..5 and shift=0, DEPTH=4.
 -> entries 1..4 held with stable out_data=1; fifth dropped; drop=1; count=4.
 -> then out_ready=1: outputs 1,2,3,4 on consecutive cycles.
REQ-035 Full plus simultaneous pop: FIFO full, out_ready=1 in the write cycle.
 -> no drop; the new value appears last in order.
REQ-036 mac_done held high for 6 cycles.
 -> exactly one result; count=1.
REQ-037 clr and reset interaction:
 - clr asserted with 3 entries buffered -> out_valid=0 next cycle; sat, drop and count all 0;
 - rst_n pulsed low mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/ofm_drain.sv
// Output drain for one PE column: captures the final partial sum on mac_done's rising
// edge, requantizes it to IWIDTH (round half up, saturate) and queues it for downstream.
module ofm_drain #(
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mac_done,
  input  logic signed [OWIDTH-1:0] ofm,
  input  logic        [3:0]        shift,
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [IWIDTH-1:0] out_data,
  output logic                     sat,
  output logic                     drop,
  output logic        [7:0]        count
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = OWIDTH + 1;
  localparam logic signed [SW-1:0] MAX_V = SW'((64'sd1 <<< (IWIDTH - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] MIN_V = SW'(-(64'sd1 <<< (IWIDTH - 1)));
  localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

  // Returns {saturated, value}; one extra bit of headroom keeps the rounding add exact.
  function automatic logic [IWIDTH:0] requant(input logic signed [OWIDTH-1:0] val,
                                              input logic [3:0] sh);
    logic signed [SW-1:0] acc;
    logic [IWIDTH:0]      res;
    acc = {val[OWIDTH-1], val};
    if (sh != 4'd0) begin
      acc = acc + (SW'(1'b1) << (sh - 4'd1));
    end else begin
      acc = acc;
    end
    acc = acc >>> sh;
    if (acc > MAX_V) begin
      res = {1'b1, MAX_V[IWIDTH-1:0]};
    end else if (acc < MIN_V) begin
      res = {1'b1, MIN_V[IWIDTH-1:0]};
    end else begin
      res = {1'b0, acc[IWIDTH-1:0]};
    end
    return res;
  endfunction

  logic                     mac_done_q;
  logic                     s1_valid_q, s1_valid_d;
  logic signed [OWIDTH-1:0] s1_ofm_q, s1_ofm_d;
  logic        [3:0]        s1_shift_q, s1_shift_d;
  logic signed [IWIDTH-1:0] mem_q [DEPTH];
  logic signed [IWIDTH-1:0] mem_d [DEPTH];
  logic        [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [IWIDTH-1:0] out_data_q, out_data_d;
  logic                     sat_q, sat_d, drop_q, drop_d;
  logic        [7:0]        count_q, count_d;

  logic                     capture_s, push_s, pop_s, full_s, wr_en_s;
  logic        [IWIDTH:0]   rq_s;
  logic        [AW:0]       occ_s;
  logic        [AW-1:0]     head_s;

  // Next-state logic for the capture stage, FIFO and sticky status.
  always_comb begin
    capture_s  = mac_done & ~mac_done_q;
    rq_s       = requant(s1_ofm_q, s1_shift_q);
    occ_s      = wr_ptr_q - rd_ptr_q;
    full_s     = (occ_s == FULL_OCC);
    push_s     = s1_valid_q & ~clr;
    pop_s      = out_valid_q & out_ready & ~clr;
    // A full FIFO still accepts when the head leaves in the same cycle.
    wr_en_s    = push_s & (~full_s | pop_s);
    s1_valid_d = capture_s & ~clr;
    s1_ofm_d   = capture_s ? ofm : s1_ofm_q;
    s1_shift_d = capture_s ? shift : s1_shift_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = (wr_en_s && (wr_ptr_q[AW-1:0] == AW'(i))) ? rq_s[IWIDTH-1:0] : mem_q[i];
    end
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      sat_d    = 1'b0;
      drop_d   = 1'b0;
      count_d  = 8'd0;
    end else begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en_s};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_s};
      sat_d    = sat_q | (push_s & rq_s[IWIDTH]);
      drop_d   = drop_q | (push_s & full_s & ~pop_s);
      count_d  = count_q + {7'd0, wr_en_s};
    end
    head_s      = rd_ptr_d[AW-1:0];
    out_valid_d = (wr_ptr_d != rd_ptr_d);
    if (!out_valid_d) begin
      out_data_d = '0;
    end else begin
      out_data_d = mem_d[head_s];
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_done_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_ofm_q    <= '0;
      s1_shift_q  <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
      drop_q      <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      mac_done_q  <= mac_done;
      s1_valid_q  <= s1_valid_d;
      s1_ofm_q    <= s1_ofm_d;
      s1_shift_q  <= s1_shift_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat       = sat_q;
  assign drop      = drop_q;
  assign count     = count_q;
endmodule
